// File: rtl/serial_tx.sv
// Framed serial transmitter: start bit, DATA_W data bits LSB first, optional even
// parity, stop bit. Every output is registered except tx_ready, which is decoded from state.
module serial_tx #(
  parameter int DATA_W       = 8,
  parameter int CLKS_PER_BIT = 4,
  parameter int PARITY_EN    = 0
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_valid,
  output logic              tx_ready,
  output logic              ser_out,
  output logic              busy,
  output logic              done
);
  localparam int BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int BIT_W  = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(DATA_W - 1);

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;

  state_t            r_state;
  logic [BAUD_W-1:0] r_baud;
  logic [BIT_W-1:0]  r_bit;
  logic [DATA_W-1:0] r_shift;
  logic              r_par;
  logic              r_ser;
  logic              r_busy;
  logic              r_done;
  logic [DATA_W-1:0] w_shift_nxt;
  logic              w_baud_end;

  assign w_shift_nxt = r_shift >> 1;
  assign w_baud_end  = (r_baud == BAUD_LAST);
  assign tx_ready    = (r_state == S_IDLE) && resetn;
  assign ser_out     = r_ser;
  assign busy        = r_busy;
  assign done        = r_done;

  // The line value is loaded together with each state transition so that
  // ser_out always reflects the state it is entering in the next cycle.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_state <= S_IDLE;
      r_baud  <= '0;
      r_bit   <= '0;
      r_shift <= '0;
      r_par   <= 1'b0;
      r_ser   <= 1'b1;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          r_ser <= 1'b1;
          if (tx_valid) begin
            r_shift <= tx_data;
            r_par   <= ^tx_data;
            r_baud  <= '0;
            r_bit   <= '0;
            r_ser   <= 1'b0;
            r_busy  <= 1'b1;
            r_state <= S_START;
          end
        end
        S_START: begin
          if (w_baud_end) begin
            r_baud  <= '0;
            r_ser   <= r_shift[0];
            r_state <= S_DATA;
          end else begin
            r_baud <= r_baud + 1'b1;
          end
        end
        S_DATA: begin
          if (w_baud_end) begin
            r_baud <= '0;
            if (r_bit == BIT_LAST) begin
              if (PARITY_EN != 0) begin
                r_ser   <= r_par;
                r_state <= S_PARITY;
              end else begin
                r_ser   <= 1'b1;
                r_state <= S_STOP;
              end
            end else begin
              r_bit   <= r_bit + 1'b1;
              r_shift <= w_shift_nxt;
              r_ser   <= w_shift_nxt[0];
            end
          end else begin
            r_baud <= r_baud + 1'b1;
          end
        end
        S_PARITY: begin
          if (w_baud_end) begin
            r_baud  <= '0;
            r_ser   <= 1'b1;
            r_state <= S_STOP;
          end else begin
            r_baud <= r_baud + 1'b1;
          end
        end
        S_STOP: begin
          if (w_baud_end) begin
            r_baud  <= '0;
            r_ser   <= 1'b1;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_state <= S_IDLE;
          end else begin
            r_baud <= r_baud + 1'b1;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_ser   <= 1'b1;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_serial_tx.sv
// Bench for serial_tx: three configurations (4 clk/bit, 4 clk/bit + parity, 1 clk/bit)
// checked cycle by cycle against a bit-list model of the frame.
module tb_serial_tx;
  logic       clk = 1'b0;
  logic       resetn = 1'b0;
  logic [7:0] d [3];
  logic       v [3];
  logic       rdy [3];
  logic       ser [3];
  logic       bsy [3];
  logic       dn [3];
  int         cmp = 0;
  int         err = 0;

  always #5 clk = ~clk;

  serial_tx #(.DATA_W(8), .CLKS_PER_BIT(4), .PARITY_EN(0)) u0 (
    .clk(clk), .resetn(resetn), .tx_data(d[0]), .tx_valid(v[0]),
    .tx_ready(rdy[0]), .ser_out(ser[0]), .busy(bsy[0]), .done(dn[0]));
  serial_tx #(.DATA_W(8), .CLKS_PER_BIT(4), .PARITY_EN(1)) u1 (
    .clk(clk), .resetn(resetn), .tx_data(d[1]), .tx_valid(v[1]),
    .tx_ready(rdy[1]), .ser_out(ser[1]), .busy(bsy[1]), .done(dn[1]));
  serial_tx #(.DATA_W(8), .CLKS_PER_BIT(1), .PARITY_EN(0)) u2 (
    .clk(clk), .resetn(resetn), .tx_data(d[2]), .tx_valid(v[2]),
    .tx_ready(rdy[2]), .ser_out(ser[2]), .busy(bsy[2]), .done(dn[2]));

  function automatic int cpb_of(int k);
    return (k == 2) ? 1 : 4;
  endfunction

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    cmp++;
    assert (obs === exp) else begin
      err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Call at a negedge while instance k is idle. Ends at the negedge of the done cycle.
  task automatic run_frame(int k, logic [7:0] dat, bit keep, logic [7:0] post);
    logic bits [$];
    logic line [$];
    bits.push_back(1'b0);
    for (int i = 0; i < 8; i++) bits.push_back(dat[i]);
    if (k == 1) bits.push_back(^dat);
    bits.push_back(1'b1);
    foreach (bits[i]) for (int c = 0; c < cpb_of(k); c++) line.push_back(bits[i]);
    d[k] = dat;
    v[k] = 1'b1;
    chk("ready_before_accept", 32'(rdy[k]), 32'd1);
    @(posedge clk);
    #1;
    v[k] = keep;
    d[k] = post;
    foreach (line[i]) begin
      @(negedge clk);
      chk($sformatf("ser k%0d d%02h c%0d", k, dat, i + 1), 32'(ser[k]), 32'(line[i]));
      chk("busy_in_frame", 32'(bsy[k]), 32'd1);
      chk("done_in_frame", 32'(dn[k]), 32'd0);
      chk("ready_in_frame", 32'(rdy[k]), 32'd0);
    end
    @(negedge clk);
    chk($sformatf("done_pulse k%0d", k), 32'(dn[k]), 32'd1);
    chk("ready_at_done", 32'(rdy[k]), 32'd1);
    chk("ser_at_done", 32'(ser[k]), 32'd1);
    chk("busy_at_done", 32'(bsy[k]), 32'd0);
  endtask

  initial begin
    for (int k = 0; k < 3; k++) begin
      d[k] = 8'hFF;
      v[k] = 1'b1;
    end
    // Reset held with a word offered: nothing may start.
    repeat (3) begin
      @(negedge clk);
      for (int k = 0; k < 3; k++) begin
        chk("rst_ser", 32'(ser[k]), 32'd1);
        chk("rst_ready", 32'(rdy[k]), 32'd0);
        chk("rst_busy", 32'(bsy[k]), 32'd0);
        chk("rst_done", 32'(dn[k]), 32'd0);
      end
    end
    for (int k = 0; k < 3; k++) v[k] = 1'b0;
    resetn = 1'b1;
    @(negedge clk);
    for (int k = 0; k < 3; k++) chk("ready_after_rst", 32'(rdy[k]), 32'd1);

    run_frame(0, 8'hA5, 1'b0, 8'h00);
    @(negedge clk);
    chk("idle_after_done", 32'(dn[0]), 32'd0);
    run_frame(1, 8'h07, 1'b0, 8'h00);
    @(negedge clk);
    run_frame(1, 8'hA5, 1'b0, 8'h00);
    @(negedge clk);
    // Back-to-back: the second word is accepted in the done cycle.
    run_frame(0, 8'h3C, 1'b1, 8'h3C);
    run_frame(0, 8'hC3, 1'b0, 8'h00);
    @(negedge clk);
    run_frame(2, 8'h81, 1'b0, 8'h00);
    @(negedge clk);

    // Abort during the third data bit (clk/bit 4: cycles 13..16 after accept).
    d[0] = 8'hF3;
    v[0] = 1'b1;
    @(posedge clk);
    #1;
    v[0] = 1'b0;
    repeat (14) @(negedge clk);
    chk("third_bit", 32'(ser[0]), 32'd0);
    resetn = 1'b0;
    @(negedge clk);
    chk("abort_ser", 32'(ser[0]), 32'd1);
    chk("abort_busy", 32'(bsy[0]), 32'd0);
    chk("abort_done", 32'(dn[0]), 32'd0);
    chk("abort_ready", 32'(rdy[0]), 32'd0);
    resetn = 1'b1;
    @(negedge clk);
    chk("post_abort_ready", 32'(rdy[0]), 32'd1);
    chk("post_abort_done", 32'(dn[0]), 32'd0);
    run_frame(0, 8'h5A, 1'b0, 8'h00);
    @(negedge clk);

    // Random words, random back-to-back chaining and idle gaps, each configuration.
    for (int k = 0; k < 3; k++) begin
      for (int n = 0; n < 8; n++) begin
        bit keep;
        logic [7:0] w;
        keep = (n != 7) && ($urandom_range(0, 1) == 1);
        w = 8'($urandom);
        run_frame(k, w, keep, 8'($urandom));
        if (!keep) begin
          int gap;
          gap = $urandom_range(1, 3);
          repeat (gap) begin
            @(negedge clk);
            chk("gap_ser", 32'(ser[k]), 32'd1);
            chk("gap_ready", 32'(rdy[k]), 32'd1);
            chk("gap_done", 32'(dn[k]), 32'd0);
          end
        end
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, err);
    $finish;
  end
endmodule
